// File: rtl/aes_pkg.sv
// Shared AES definitions: round/word geometry, Rcon seed, GF(2^8) xtime
// and the key-schedule FSM state type.
package aes_pkg;

    localparam int NR      = 10;
    localparam int NB      = 4;
    localparam int WORD_W  = 32;
    localparam int STATE_W = NB * WORD_W;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared by SubBytes and the key schedule.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] substituted
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign substituted = SBOX[value];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, read back through a registered port.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR       = aes_pkg::NR,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [127:0]        key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic                rk_rd_en,
    input  logic [RK_IDX_W-1:0] rk_rd_idx,
    output logic [127:0]        rk_rd_data,
    output logic                rk_rd_valid
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_key_schedule supports only NR = 10 (AES-128)");
        end
    endgenerate

    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);

    ks_state_t           state;
    logic [WORD_W-1:0]   w0, w1, w2, w3;
    logic [7:0]          rcon;
    logic [RK_IDX_W-1:0] round;
    logic [STATE_W-1:0]  rk_file [0:NR];

    logic [WORD_W-1:0]   rot_w, sub_w, t;
    logic [WORD_W-1:0]   n0, n1, n2, n3;
    logic                accept;

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < NB; b++) begin : g_sbox
        aes_sbox u_sbox (
            .value       (rot_w[8*b +: 8]),
            .substituted (sub_w[8*b +: 8])
        );
    end

    assign t  = sub_w ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    // key_ready is registered and only high in IDLE/DONE, so it alone qualifies the handshake.
    assign accept = key_valid && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rcon       <= RCON_INIT;
            round      <= '0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            w3         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        {w0, w1, w2, w3} <= key_in;
                        round      <= RK_IDX_W'(1);
                        rcon       <= RCON_INIT;
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    {w0, w1, w2, w3} <= {n0, n1, n2, n3};
                    rcon  <= xtime(rcon);
                    round <= round + 1'b1;
                    if (round == LAST_IDX) begin
                        state      <= ST_DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage only; keys_valid qualifies the contents, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept && (state != ST_EXPAND)) begin
            rk_file[0] <= key_in;
        end else if (state == ST_EXPAND) begin
            rk_file[round] <= {n0, n1, n2, n3};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_rd_valid <= 1'b0;
            rk_rd_data  <= '0;
        end else begin
            rk_rd_valid <= rk_rd_en;
            if (rk_rd_en) begin
                rk_rd_data <= (rk_rd_idx <= LAST_IDX) ? rk_file[rk_rd_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a GF(2^8)-derived key expansion model.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_rd_idx = '0;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb  [256];
    logic [127:0] mdl [11];

    aes_key_schedule #(.NR(10), .RK_IDX_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_expand(input string tag, input logic [127:0] key,
                              input logic [127:0] other, input bit hold);
        int first = -1;
        int nd = 0;
        int nlow = 0;
        key_valid = 1'b1;
        key_in    = key;
        check({tag, "_ready_before"}, 128'(key_ready), 128'd1);
        tick();
        if (hold) key_in = other;
        else key_valid = 1'b0;
        check({tag, "_keys_valid_drop"}, 128'(keys_valid), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        for (int i = 1; i <= 14; i++) begin
            if (!key_ready) nlow++;
            else key_valid = 1'b0;
            tick();
            if (done) begin
                nd++;
                if (first < 0) first = i;
            end
        end
        key_valid = 1'b0;
        check({tag, "_done_latency"}, 128'(first), 128'd10);
        check({tag, "_done_pulses"}, 128'(nd), 128'd1);
        check({tag, "_ready_low_cycles"}, 128'(nlow), 128'd10);
        check({tag, "_keys_valid_set"}, 128'(keys_valid), 128'd1);
        check({tag, "_busy_clear"}, 128'(busy), 128'd0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] idx, input logic [127:0] expected);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        check({tag, "_valid_pre"}, 128'(rk_rd_valid), 128'd0);
        tick();
        check({tag, "_valid"}, 128'(rk_rd_valid), 128'd1);
        check({tag, "_data"}, rk_rd_data, expected);
        rk_rd_en = 1'b0;
        tick();
        check({tag, "_valid_off"}, 128'(rk_rd_valid), 128'd0);
        check({tag, "_data_hold"}, rk_rd_data, expected);
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r <= 10; r++) read_check($sformatf("%s_rk%0d", tag, r), 4'(r), mdl[r]);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] k, k2;
        logic [3:0]   ri;
        int           nd;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

        // Reset values
        #12;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_rd_valid", 128'(rk_rd_valid), 128'd0);
        check("rst_rd_data", rk_rd_data, 128'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // FIPS-197 Appendix A key
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        run_expand("fips", k, '0, 1'b0);
        read_check("fips_rk0_key", 4'd0, k);
        read_check("fips_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_check("fips_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep("fips");
        read_check("oor_idx11", 4'd11, 128'h0);
        read_check("oor_idx15", 4'd15, 128'h0);

        // Key held valid with a different value during EXPAND is ignored
        k  = rand_key();
        k2 = rand_key();
        model_expand(k);
        run_expand("hold", k, k2, 1'b1);
        sweep("hold");

        // Appendix C key accepted from DONE
        k = 128'h000102030405060708090a0b0c0d0e0f;
        model_expand(k);
        run_expand("c1", k, '0, 1'b0);
        read_check("c1_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        sweep("c1");

        // Random keys with random reads, including out-of-range indices
        for (int n = 0; n < 3; n++) begin
            k = rand_key();
            model_expand(k);
            run_expand($sformatf("rnd%0d", n), k, '0, 1'b0);
            for (int j = 0; j < 6; j++) begin
                ri = 4'($urandom_range(0, 15));
                read_check($sformatf("rnd%0d_rd%0d", n, ri), ri, (ri <= 4'd10) ? mdl[ri] : 128'h0);
            end
        end

        // Reset asserted mid-expansion, after round 5 has been written
        k = rand_key();
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy_before_reset", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_key_ready", 128'(key_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        check("mid_no_done", 128'(nd), 128'd0);
        check("mid_keys_valid_stays_low", 128'(keys_valid), 128'd0);
        check("mid_ready_idle", 128'(key_ready), 128'd1);
        k = rand_key();
        model_expand(k);
        run_expand("post_rst", k, '0, 1'b0);
        sweep("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
